fs_serial: RTL
==============

Name: fs_serial

Overview:
- Parametrised multi-bit subtractor built from the one-bit full-subtractor cell.
- Iterates the cell over a WIDTH-bit operand, processing BITS_PER_CYCLE bits per clock, LSB chunk first.
- Computes Diff = A - B - Borrow_in with Borrow_out, zero and signed-overflow flags, under a start/busy/done handshake.
- Used where area matters more than latency; throughput and latency are tuned by BITS_PER_CYCLE.

Parameters:
- WIDTH, 8, operand and result width in bits; must be >= 1.
- BITS_PER_CYCLE, 1, bits processed per RUN cycle; must satisfy 1 <= BITS_PER_CYCLE <= WIDTH and divide WIDTH, else elaboration error.
- Derived: STEPS = WIDTH / BITS_PER_CYCLE.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  minuend; captured on the accepted start edge.
- B  input  WIDTH  subtrahend; captured on the accepted start edge.
- Borrow_in  input  1  borrow into bit 0; captured on the accepted start edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; results valid and newly updated.
- Diff  output  WIDTH  result, A - B - Borrow_in mod 2^WIDTH.
- Borrow_out  output  1  1 iff A < B + Borrow_in (unsigned).
- zero  output  1  1 iff Diff == 0.
- ovf  output  1  signed overflow = borrow into MSB XOR Borrow_out.

Behaviour:
- Reset: rst high at an edge forces state IDLE, step counter 0, and busy, done, Diff, Borrow_out, zero, ovf all 0. Reset wins over start and over any in-flight operation; partial results are discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1: load A, B and Borrow_in into internal shift/borrow registers, set counter=0, go to RUN.
  - With start=0: stay in IDLE.
- RUN (busy=1):
  - Each edge processes the lowest unprocessed BITS_PER_CYCLE-bit chunk through a ripple of full-subtractor cells.
  - The chunk's borrow-out is registered as the borrow-in of the next chunk.
  - Counter increments each edge. On the edge where counter == STEPS-1, go to DONE.
  - RUN lasts exactly STEPS cycles.
- DONE:
  - Entering DONE updates Diff, Borrow_out, zero and ovf together.
  - done=1 for exactly one cycle, then IDLE on the next edge.
- Timing: if start is accepted at edge t0, busy is high for the cycles following edges t0 .. t0+STEPS-1, and done is high for the cycle following edge t0+STEPS. Minimum start-to-start spacing is STEPS+2 edges.
- start while in RUN or DONE is ignored; it is not queued. Operand changes after capture have no effect.
- Result outputs hold their last value (or 0 after reset) until the next DONE entry; they do not change during RUN.
- STEPS=1 (BITS_PER_CYCLE=WIDTH): RUN is one cycle, and done follows the start edge by one edge.
- Wrap-around: the result is modulo 2^WIDTH. The borrow into the MSB is the borrow out of bit WIDTH-2; for WIDTH=1 it is Borrow_in.

Test Plan:
- Reset: hold rst for 2 cycles, with start=1 asserted during reset -> busy=done=Diff=Borrow_out=zero=ovf=0, no RUN entered.
- WIDTH=8, BPC=1: start with A=0x05, B=0x03, Borrow_in=0 -> busy high for exactly 8 cycles, done pulse 1 cycle, Diff=0x02, Borrow_out=0, zero=0, ovf=0.
- WIDTH=8, BPC=1, borrow and overflow cases:
  - A=0x00, B=0x01, Borrow_in=1 -> Diff=0xFE, Borrow_out=1, ovf=0.
  - A=0x80, B=0x01, Borrow_in=0 -> Diff=0x7F, Borrow_out=0, ovf=1.
  - A=0x7F, B=0x7F, Borrow_in=0 -> Diff=0x00, zero=1.
- Handshake abuse:
  - Pulse start with A=0xFF, B=0x00 on the 3rd RUN cycle of a 0x05-0x03 operation -> ignored; result still 0x02.
  - Assert rst on the 4th RUN cycle -> all outputs 0 next cycle; a following start with A=0x10, B=0x01 gives Diff=0x0F.
- Exhaustive, WIDTH=4 with BPC=1, 2 and 4: all 512 (A, B, Borrow_in) combinations -> match the (A-B-Borrow_in) mod 16 / borrow / zero / ovf model; done exactly STEPS edges after each accepted start.

Source files
------------

// File: rtl/fs_serial.sv
// Serial multi-bit subtractor: iterates a ripple of one-bit full-subtractor cells
// over the operands, BITS_PER_CYCLE bits per clock, LSB chunk first.
module fs_serial #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow_out,
  output logic             zero,
  output logic             ovf
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  generate
    if (WIDTH < 1 || BITS_PER_CYCLE < 1 || BITS_PER_CYCLE > WIDTH ||
        (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_params
      $error("fs_serial: BITS_PER_CYCLE must lie in 1..WIDTH and divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               borrow_q, borrow_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               borrow_out_q, borrow_out_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;

  logic [BITS_PER_CYCLE:0]   chain;
  logic [BITS_PER_CYCLE-1:0] chunk_diff;
  logic [WIDTH-1:0]          acc_next;

  // One chunk of full-subtractor cells; chain[i] is the borrow into bit i of the chunk.
  always_comb begin
    chain      = '0;
    chunk_diff = '0;
    chain[0]   = borrow_q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      chunk_diff[i] = a_q[i] ^ b_q[i] ^ chain[i];
      chain[i+1]    = (~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & chain[i]);
    end
    acc_next = (acc_q >> BITS_PER_CYCLE) |
               (WIDTH'(chunk_diff) << (WIDTH - BITS_PER_CYCLE));
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    borrow_d     = borrow_q;
    acc_d        = acc_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    zero_d       = zero_q;
    ovf_d        = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = A;
          b_d      = B;
          borrow_d = Borrow_in;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_d      = a_q >> BITS_PER_CYCLE;
        b_d      = b_q >> BITS_PER_CYCLE;
        borrow_d = chain[BITS_PER_CYCLE];
        acc_d    = acc_next;
        cnt_d    = cnt_q + CNT_W'(1);
        // On the final chunk its top cell holds the MSB, so chain gives both ovf terms.
        if (cnt_q == CNT_W'(STEPS - 1)) begin
          state_d      = DONE;
          cnt_d        = '0;
          diff_d       = acc_next;
          borrow_out_d = chain[BITS_PER_CYCLE];
          zero_d       = (acc_next == '0);
          ovf_d        = chain[BITS_PER_CYCLE-1] ^ chain[BITS_PER_CYCLE];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      borrow_q     <= 1'b0;
      acc_q        <= '0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      zero_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      borrow_q     <= borrow_d;
      acc_q        <= acc_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      zero_q       <= zero_d;
      ovf_q        <= ovf_d;
    end
  end

  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign Diff       = diff_q;
  assign Borrow_out = borrow_out_q;
  assign zero       = zero_q;
  assign ovf        = ovf_q;

endmodule
